// File: rtl/rv_g_regfile_wr_arbiter.sv
// Regfile write-port arbiter. NUM_REQ writeback sources share the single
// rv_g_regfile write port through round-robin arbitration with valid/ready.
// The winning write is registered, so the regfile sees it one cycle after the
// grant. Integer x0 writes are consumed without writing. FP results are
// NaN-boxed and narrow integer results are zero-extended.

// Per-requester data formatter: NaN-box FP data, zero-extend integer data.
module rv_g_regfile_wr_fmt #(
    parameter int XLEN    = 64,
    parameter int FLEN    = 32,
    parameter int MAX_LEN = 64
) (
    input  logic               is_fp,
    input  logic [MAX_LEN-1:0] data_in,
    output logic [MAX_LEN-1:0] data_out
);
    // Bits that carry the value for each register class. All bits above
    // the class width are forced: ones for FP (NaN box), zeros for integer.
    localparam logic [MAX_LEN-1:0] F_KEEP = {MAX_LEN{1'b1}} >> (MAX_LEN - FLEN);
    localparam logic [MAX_LEN-1:0] X_KEEP = {MAX_LEN{1'b1}} >> (MAX_LEN - XLEN);

    // Select boxing or zero-fill by destination register class.
    always_comb begin
        data_out = data_in & X_KEEP;
        if (is_fp) begin
            data_out = (data_in & F_KEEP) | ~F_KEEP;
        end
    end
endmodule

module rv_g_regfile_wr_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  XLEN    = 64,
    parameter int  FLEN    = 32,
    localparam int MAX_LEN = (XLEN > FLEN) ? XLEN : FLEN,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              arst_ni,
    input  logic                              hold_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0][5:0]           req_addr_i,
    input  logic [NUM_REQ-1:0][MAX_LEN-1:0]   req_data_i,
    output logic [5:0]                        wr_addr_o,
    output logic [MAX_LEN-1:0]                wr_data_o,
    output logic                              wr_en_o,
    output logic [IDX_W-1:0]                  wr_src_o
);
    logic [IDX_W-1:0]                rr_ptr;
    logic [IDX_W-1:0]                gnt_idx;
    logic [IDX_W-1:0]                scan_idx;
    logic                            gnt_found;
    logic [NUM_REQ-1:0]              gnt_vec;
    logic                            fire;
    logic [NUM_REQ-1:0][MAX_LEN-1:0] fmt_data;

    // Formatting happens per requester ahead of the capture mux so the
    // registered path only sees a select.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fmt
        rv_g_regfile_wr_fmt #(
            .XLEN   (XLEN),
            .FLEN   (FLEN),
            .MAX_LEN(MAX_LEN)
        ) u_fmt (
            .is_fp   (req_addr_i[g][5]),
            .data_in (req_data_i[g]),
            .data_out(fmt_data[g])
        );
    end

    // Round-robin scan: first valid at or above the pointer, modulo NUM_REQ.
    always_comb begin
        gnt_vec   = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!gnt_found && req_valid_i[scan_idx]) begin
                gnt_found         = 1'b1;
                gnt_idx           = scan_idx;
                gnt_vec[scan_idx] = 1'b1;
            end
        end
    end

    // Ready is suppressed by hold and also while reset is held, so nothing
    // can be consumed while the output register is being cleared.
    assign req_ready_o = (arst_ni && !hold_i) ? gnt_vec : '0;
    assign fire        = |req_ready_o;

    // Pointer moves just past the winner; it stays put on idle or hold cycles.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rr_ptr <= '0;
        end else if (fire) begin
            rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Output register: capture the winner; enable is a one-cycle pulse and
    // is withheld for x0 so that slot is consumed without a write.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            wr_src_o  <= '0;
        end else if (fire) begin
            wr_en_o   <= (req_addr_i[gnt_idx] != 6'd0);
            wr_addr_o <= req_addr_i[gnt_idx];
            wr_data_o <= fmt_data[gnt_idx];
            wr_src_o  <= gnt_idx;
        end else begin
            wr_en_o   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rv_g_regfile_wr_arbiter.sv
// Directed bench for rv_g_regfile_wr_arbiter: each cycle the expected grant is
// checked and the expected regfile write is queued, then popped one cycle later.
module tb_rv_g_regfile_wr_arbiter;
    logic             clk_i = 1'b0;
    logic             arst_ni;
    logic             hold_i;
    logic [3:0]       req_valid_i;
    logic [3:0]       req_ready_o;
    logic [3:0][5:0]  req_addr_i;
    logic [3:0][63:0] req_data_i;
    logic [5:0]       wr_addr_o;
    logic [63:0]      wr_data_o;
    logic             wr_en_o;
    logic [1:0]       wr_src_o;

    rv_g_regfile_wr_arbiter #(.NUM_REQ(4), .XLEN(64), .FLEN(32)) dut (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .hold_i     (hold_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .wr_en_o    (wr_en_o),
        .wr_src_o   (wr_src_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        en;
        logic [5:0]  addr;
        logic [63:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] rf[64];

    localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D3 = 64'h9999_AAAA_BBBB_CCCC;

    // Regfile model: takes whatever the write port presents at each edge.
    always @(posedge clk_i) begin
        if (wr_en_o) rf[wr_addr_o] <= wr_data_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] boxed(input logic [5:0] a, input logic [63:0] d);
        return a[5] ? {32'hFFFF_FFFF, d[31:0]} : d;
    endfunction

    // One cycle: check last cycle's write, check this cycle's grant, queue its write.
    task automatic cyc(input logic [3:0] exp_rdy);
        exp_t e;
        @(negedge clk_i);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_en", {63'd0, wr_en_o}, {63'd0, e.en});
            if (e.en) begin
                chk("wr_addr", {58'd0, wr_addr_o}, {58'd0, e.addr});
                chk("wr_data", wr_data_o, e.data);
                chk("wr_src", {62'd0, wr_src_o}, {62'd0, e.src});
            end
        end
        chk("ready", {60'd0, req_ready_o}, {60'd0, exp_rdy});
        e = '{en: 1'b0, addr: 6'd0, data: 64'd0, src: 2'd0};
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                e.en   = (req_addr_i[i] != 6'd0);
                e.addr = req_addr_i[i];
                e.data = boxed(req_addr_i[i], req_data_i[i]);
                e.src  = 2'(i);
            end
        end
        q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 64; i++) rf[i] = 64'd0;
        arst_ni     = 1'b0;
        hold_i      = 1'b0;
        req_valid_i = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_addr_i[i] = 6'(i + 1);
            req_data_i[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
        end

        // Reset: outputs cleared and no ready even with valids present.
        #50;
        chk("rst_wr_en", {63'd0, wr_en_o}, 64'd0);
        chk("rst_wr_addr", {58'd0, wr_addr_o}, 64'd0);
        chk("rst_wr_data", wr_data_o, 64'd0);
        chk("rst_wr_src", {62'd0, wr_src_o}, 64'd0);
        chk("rst_ready", {60'd0, req_ready_o}, 64'd0);
        req_valid_i = 4'b0000;
        #50;
        arst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Idle after reset.
        cyc(4'b0000);
        cyc(4'b0000);

        // Single integer write from requester 2 (pointer 0 -> 3).
        req_addr_i[2] = 6'd5;
        req_data_i[2] = 64'hDEAD_BEEF_0123_4567;
        req_valid_i   = 4'b0100;
        cyc(4'b0100);
        // FP write from requester 3 brings the pointer back to 0.
        req_addr_i[3] = 6'd33;
        req_data_i[3] = 64'h1234_5678_9ABC_DEF0;
        req_valid_i   = 4'b1000;
        cyc(4'b1000);
        req_valid_i   = 4'b0000;
        cyc(4'b0000);

        // Round-robin under full load for 8 cycles.
        for (int i = 0; i < 4; i++) begin
            req_addr_i[i] = 6'(i + 12);
            req_data_i[i] = 64'h0F0F_0000_0000_0000 + 64'(i * 3);
        end
        req_valid_i = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            cyc(4'b0001);
            cyc(4'b0010);
            cyc(4'b0100);
            cyc(4'b1000);
        end
        req_valid_i = 4'b0000;
        cyc(4'b0000);

        // Hold with contention on x10.
        req_addr_i[1] = 6'd10;
        req_data_i[1] = D1;
        req_addr_i[3] = 6'd10;
        req_data_i[3] = D3;
        req_valid_i   = 4'b1010;
        hold_i        = 1'b1;
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0000);
        hold_i        = 1'b0;
        cyc(4'b0010);
        // Hold right after a grant must not cancel the registered write.
        req_valid_i   = 4'b1000;
        hold_i        = 1'b1;
        cyc(4'b0000);
        hold_i        = 1'b0;
        cyc(4'b1000);
        req_valid_i   = 4'b0000;
        cyc(4'b0000);
        cyc(4'b0000);
        chk("rf_x10_last_wins", rf[10], D3);
        chk("rf_x5", rf[5], 64'hDEAD_BEEF_0123_4567);

        // x0 drop, then f0 normal write with NaN boxing (pointer 0 -> 1).
        req_addr_i[0] = 6'd0;
        req_data_i[0] = 64'h1;
        req_valid_i   = 4'b0001;
        cyc(4'b0001);
        req_addr_i[0] = 6'd32;
        req_data_i[0] = 64'h3F80_0000;
        cyc(4'b0001);
        req_valid_i   = 4'b0000;
        cyc(4'b0000);
        chk("rf_x0_untouched", rf[0], 64'd0);
        chk("rf_f0", rf[32], 64'hFFFF_FFFF_3F80_0000);

        // Mid-operation reset: the registered write is discarded.
        req_addr_i[0] = 6'd7;
        req_data_i[0] = 64'h7777_0000_0000_7777;
        req_valid_i   = 4'b0001;
        cyc(4'b0001);
        req_valid_i   = 4'b0000;
        @(negedge clk_i);
        e = q.pop_front();
        chk("pre_rst_wr_en", {63'd0, wr_en_o}, {63'd0, e.en});
        #2;
        arst_ni = 1'b0;
        #1;
        chk("mid_rst_wr_en", {63'd0, wr_en_o}, 64'd0);
        chk("mid_rst_wr_data", wr_data_o, 64'd0);
        @(posedge clk_i);
        #1;
        chk("rf_x7_not_written", rf[7], 64'd0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        q.delete();
        @(posedge clk_i);
        #1;
        // Pointer back at 0: requester 0 wins with everyone valid.
        req_valid_i = 4'b1111;
        cyc(4'b0001);
        req_valid_i = 4'b0000;
        cyc(4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rv_g_regfile_wr_arbiter.md
Name: rv_g_regfile_wr_arbiter

Overview:
Shares the single write port of rv_g_regfile between NUM_REQ writeback sources (ALU, MUL/DIV, LSU, FPU) using round-robin arbitration with valid/ready handshakes. The winning write is registered and presented to the regfile one cycle later as wr_addr_i / wr_data_i / wr_en_i. Writes to integer x0 are dropped. Single-precision results written to FP registers are NaN-boxed. The block sits between the execute-stage writeback buses and the regfile.

Parameters:
NUM_REQ, 4, number of writeback requesters (>=2)
XLEN, 64, integer register width
FLEN, 32, floating-point register width
(derived localparam MAX_LEN = max(XLEN, FLEN); IDX_W = $clog2(NUM_REQ))

Ports:
clk_i  in  1  clock, rising edge
arst_ni  in  1  asynchronous active-low reset
hold_i  in  1  freezes arbitration; no grants while high
req_valid_i  in  NUM_REQ  per-requester write request
req_ready_o  out  NUM_REQ  per-requester grant (one-hot or zero)
req_addr_i  in  NUM_REQ x 6  destination; bit5=0 integer xN, bit5=1 float fN
req_data_i  in  NUM_REQ x MAX_LEN  write data
wr_addr_o  out  6  to regfile wr_addr_i
wr_data_o  out  MAX_LEN  to regfile wr_data_i
wr_en_o  out  1  to regfile wr_en_i
wr_src_o  out  IDX_W  index of requester whose write is on wr_*_o

Behaviour:
- Reset (arst_ni=0, async): wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_src_o=0, RR pointer=0. req_ready_o is all zero while reset is asserted. Any registered write in flight is discarded.
- Arbitration is combinational within the cycle. Starting at the RR pointer and scanning upward modulo NUM_REQ, the first index with req_valid_i=1 wins. req_ready_o has that single bit set.
- If hold_i=1 or no valid is present, req_ready_o=0 and the pointer is unchanged.
- Handshake fires on valid&ready at a rising edge. After a grant to index k, the pointer becomes (k+1) mod NUM_REQ, and the pointer wraps from NUM_REQ-1 to 0.
- A requester keeps valid, addr and data stable until it is granted. Valid never depends on ready.
- Output register: on a handshake edge, capture addr, data and index. wr_en_o=1 for exactly the next cycle only, unless the write is dropped. With no handshake, wr_en_o=0 next cycle and wr_addr_o/wr_data_o/wr_src_o hold their previous values.
- Latency: grant in cycle N gives a regfile write at the edge ending cycle N+1. Throughput is 1 write per cycle.
- x0 drop: an accepted request with addr=6'd0 is consumed (ready asserted, pointer advances), but wr_en_o stays 0 for that slot. Float f0 (addr=6'd32) is a normal write.
- NaN-boxing: if addr[5]=1 and FLEN<MAX_LEN, wr_data_o = {(MAX_LEN-FLEN) ones, data[FLEN-1:0]}. If addr[5]=0 and XLEN<MAX_LEN, upper bits are zero-filled. Otherwise data passes unchanged.
- Same destination from two requesters in one cycle: only the winner is granted. The loser writes in a later cycle, so the last write in time wins. No merging.
- hold_i asserted on the cycle after a grant does not cancel the already-registered write. wr_en_o still pulses.
- All-valid continuous load: grants cycle 0,1,2,3,0,... with no starvation. Any valid requester is granted within NUM_REQ cycles unless hold_i is high.

Test Plan:
- Reset then idle: arst_ni low 100ns -> all outputs 0. After release with no valid, wr_en_o stays 0 and req_ready_o=0.
- Single write: req 2 valid, addr=6'd5, data=64'hDEAD_BEEF_0123_4567 -> ready[2]=1 in cycle N. In N+1: wr_en_o=1, wr_addr_o=5, wr_data_o equals the data, wr_src_o=2.
- Round-robin fairness: all 4 valid and held for 8 cycles -> grant order 0,1,2,3,0,1,2,3. wr_en_o=1 for 8 consecutive cycles, and wr_src_o lags the grant by one cycle.
- x0 drop and f0 write: req0 addr=0 data=64'h1 -> ready[0]=1 and wr_en_o=0 next cycle. Then addr=6'd32 data=64'h3F80_0000 -> wr_en_o=1, wr_data_o=64'hFFFF_FFFF_3F80_0000.
- hold and contention: req1 and req3 both valid, addr=6'd10, hold_i=1 for 3 cycles -> no ready. After release (pointer=0), req1 writes first, then req3, so regfile x10 holds req3's data.
- Mid-operation reset: grant to req0, then arst_ni low in the following cycle before the edge -> wr_en_o drops to 0 immediately and the write does not reach the regfile. After release the pointer is 0.
